serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Multi-cycle, parametrised successor to the single-bit full adder cell.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, using a registered carry between digits.
- Uses a start/busy/done handshake so a narrow adder slice can serve wide datapaths in the ALU and test fixtures.
- Holds the last result stable until the next operation completes.

Parameters:
- WIDTH, 8, operand and result width in bits; WIDTH >= 2.
- DIGIT, 1, bits processed per clock; must divide WIDTH exactly. N = WIDTH/DIGIT digit cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1 with cin ignored
- a  input  WIDTH  operand A, latched on accepted start
- b  input  WIDTH  operand B, latched on accepted start
- cin  input  1  carry-in for add mode, latched on accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; sum/cout are valid from this cycle
- sum  output  WIDTH  result, held between operations
- cout  output  1  carry-out; in sub mode 1 = no borrow (a >= b unsigned)

Behaviour:
- Reset: on any clk edge with rst=1, state=IDLE; busy=0, done=0, sum=0, cout=0, internal shift registers and carry cleared. rst wins over every other input.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches a, (sub ? ~b : b), and carry = (sub ? 1 : cin).
  - digit counter cleared to 0; state goes to RUN.
  - busy=1 from the next cycle.
- RUN:
  - each edge adds the low DIGIT bits of both operand shift registers plus the carry register.
  - the DIGIT-bit digit sum is shifted into the top of the result shift register; the carry register is updated; operand registers shift right by DIGIT.
  - counter increments; on the edge processing digit N-1, state goes to DONE.
- DONE entry (same edge as the last digit): sum <= full result register, cout <= final carry, done=1, busy=0.
- Latency: done rises N edges after the edge that sampled start. WIDTH=8, DIGIT=1: 8 cycles. WIDTH=8, DIGIT=4: 2 cycles.
- DONE: lasts exactly one cycle.
  - start=1 in this cycle is accepted as in IDLE (back-to-back operation, no bubble).
  - otherwise go to IDLE.
- start while busy=1 is ignored. Operand, sub and cin changes during RUN have no effect.
- sum/cout change only on the DONE-entry edge or on reset. During RUN they hold the previous result.
- Arithmetic is modulo 2^WIDTH. Each digit is computed as an unsigned (DIGIT+1)-bit sum; its MSB becomes the next carry.
- rst mid-RUN: operation aborted, no done pulse, outputs return to reset values.

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- When defined: extra output port ovf (1 bit, after cout).
  - ovf is signed two's-complement overflow = carry into the MSB XOR final carry-out.
  - In DIGIT>1 mode this requires the bit-level carry into bit WIDTH-1, computed within the final digit.
  - ovf updates with sum, is 0 on reset, and holds between operations.
- When undefined: port ovf absent; no overflow logic.

Test Plan:
- Assert rst for 2 cycles mid-operation (after 3 RUN cycles) -> busy=0, done never pulses, sum=0x00, cout=0, ovf=0.
- WIDTH=8, DIGIT=1: a=0x5A, b=0x3C, cin=0, sub=0, start 1 cycle -> done exactly 8 cycles after start edge, one cycle wide; sum=0x96, cout=0; ovf=1 if enabled.
- a=0xFF, b=0x01, cin=1, sub=0 -> sum=0x01, cout=1, ovf=0. Then sub=1, a=0x10, b=0x20 -> sum=0xF0, cout=0, ovf=0.
- Start pulse with a=0x7F, b=0x01; assert start again with a=0x00 at cycle 3 of RUN -> second request ignored; sum=0x80, ovf=1. Start held high in the done cycle with a=0x01, b=0x01 -> next done 8 cycles later with sum=0x02.
- Sum-hold check: during the second operation, sum stays 0x80 until its done edge.
- DIGIT=4 instance: a=0x99, b=0x77, cin=0 -> done 2 cycles after start; sum=0x10, cout=1.
- Randomised sweep, 1000 ops, both modes, versus a behavioural a±b+cin model.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: digit-serial add/subtract of two WIDTH-bit operands, DIGIT bits per clock.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf (after cout).
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CNT_W-1:0] count;
  logic [DIGIT:0]   digit_sum;
  logic             accept;
  logic             last;

  // A new request is taken in IDLE and also in DONE, so operations can run back to back.
  assign accept    = start && (state != RUN);
  assign last      = (count == CNT_W'(N - 1));
  assign digit_sum = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry};
  assign res_next  = (res >> DIGIT) | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

`ifdef SERIAL_ADDER_OVF_EN
  // Carry into the result MSB, recovered from the MSB of the final digit: s = a ^ b ^ c.
  logic msb_carry;
  assign msb_carry = digit_sum[DIGIT-1] ^ op_a[DIGIT-1] ^ op_b[DIGIT-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      // Subtraction is a + ~b + 1, so the inverted operand and a forced carry are latched.
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      res   <= '0;
      count <= '0;
    end else if (state == RUN) begin
      op_a  <= op_a >> DIGIT;
      op_b  <= op_b >> DIGIT;
      res   <= res_next;
      carry <= digit_sum[DIGIT];
      count <= count + CNT_W'(1);
      if (last) begin
        sum  <= res_next;
        cout <= digit_sum[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
        ovf  <= msb_carry ^ digit_sum[DIGIT];
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomized checks of serial_adder (DIGIT=1 and DIGIT=4 instances)
// against an arithmetic reference model.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1;
  logic       start4;
  logic       sub;
  logic       cin;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy1, done1, cout1;
  logic       busy4, done4, cout4;
  logic [7:0] sum1, sum4;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf1, ovf4;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issues one start pulse to the chosen instance and counts cycles until done (bounded).
  // With scramble set, inputs are disturbed during RUN and a stray start may be raised.
  task automatic applyStimulus(input int which, input logic [7:0] ta, input logic [7:0] tb_v,
                               input logic tcin, input logic tsub, input bit scramble,
                               output int cycles);
    @(negedge clk);
    a = ta; b = tb_v; cin = tcin; sub = tsub;
    if (which == 1) start1 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    cycles = 0;
    while (!((which == 1) ? done1 : done4) && cycles < 20) begin
      if (scramble) begin
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        if (which == 1) start1 = (cycles == 1) ? 1'($urandom) : 1'b0;
        else            start4 = (cycles == 1) ? 1'($urandom) : 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    start1 = 1'b0; start4 = 1'b0;
  endtask

  // Reference: plain unsigned/signed arithmetic on the original operands.
  task automatic checkResult(input int which, input logic [7:0] ta, input logic [7:0] tb_v,
                             input logic tcin, input logic tsub, input int cycles,
                             input string tag);
    logic [8:0] full;
    if (tsub) begin
      full[7:0] = ta - tb_v;
      full[8]   = (ta >= tb_v);
    end else begin
      full = {1'b0, ta} + {1'b0, tb_v} + {8'd0, tcin};
    end
    checkOutput({tag, "_lat"}, cycles, (which == 1) ? 8 : 2);
    checkOutput({tag, "_sum"}, (which == 1) ? sum1 : sum4, full[7:0]);
    checkOutput({tag, "_cout"}, (which == 1) ? cout1 : cout4, full[8]);
`ifdef SERIAL_ADDER_OVF_EN
    begin
      int sa, sb, sr;
      sa = $signed(ta);
      sb = $signed(tb_v);
      sr = tsub ? (sa - sb) : (sa + sb + int'(tcin));
      checkOutput({tag, "_ovf"}, (which == 1) ? ovf1 : ovf4, (sr > 127 || sr < -128) ? 1 : 0);
    end
`endif
  endtask

  initial begin
    int   cyc;
    bit   seen;
    bit   held;
    logic [7:0] ra, rb;
    logic rcin, rsub;
    int   which;

    rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busy1, 0);
    checkOutput("rst_done", done1, 0);
    checkOutput("rst_sum", sum1, 0);
    checkOutput("rst_cout", cout1, 0);
    rst = 1'b0;

    applyStimulus(1, 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, cyc);
    checkResult(1, 8'h5A, 8'h3C, 1'b0, 1'b0, cyc, "add_5a_3c");
    checkOutput("add_5a_3c_sum_const", sum1, 8'h96);
    @(negedge clk);
    checkOutput("done_one_cycle", done1, 0);

    applyStimulus(1, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, cyc);
    checkResult(1, 8'hFF, 8'h01, 1'b1, 1'b0, cyc, "add_ff_01_c");
    applyStimulus(1, 8'h10, 8'h20, 1'b0, 1'b1, 1'b0, cyc);
    checkResult(1, 8'h10, 8'h20, 1'b0, 1'b1, cyc, "sub_10_20");
    checkOutput("sub_10_20_sum_const", sum1, 8'hF0);

    // Second start during RUN must be ignored; then a back-to-back start in the done cycle.
    @(negedge clk);
    a = 8'h7F; b = 8'h01; cin = 1'b0; sub = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    a = 8'h00; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 2;
    while (!done1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("ignore_lat", cyc, 8);
    checkOutput("ignore_sum", sum1, 8'h80);
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput("ignore_ovf", ovf1, 1);
`endif
    a = 8'h01; b = 8'h01; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 0;
    held = 1'b1;
    while (!done1 && cyc < 20) begin
      if (sum1 !== 8'h80) held = 1'b0;
      @(negedge clk);
      cyc++;
    end
    checkOutput("b2b_sum_held", held, 1);
    checkOutput("b2b_lat", cyc, 8);
    checkOutput("b2b_sum", sum1, 8'h02);

    applyStimulus(4, 8'h99, 8'h77, 1'b0, 1'b0, 1'b0, cyc);
    checkResult(4, 8'h99, 8'h77, 1'b0, 1'b0, cyc, "d4_99_77");
    checkOutput("d4_99_77_sum_const", sum4, 8'h10);

    // Reset after three RUN cycles aborts the operation without a done pulse.
    @(negedge clk);
    a = 8'hC3; b = 8'h5A; cin = 1'b1; sub = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done1) seen = 1'b1;
    end
    rst = 1'b0;
    checkOutput("midrst_busy", busy1, 0);
    checkOutput("midrst_sum", sum1, 0);
    checkOutput("midrst_cout", cout1, 0);
    checkOutput("midrst_sum4", sum4, 0);
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput("midrst_ovf", ovf1, 0);
`endif
    repeat (10) begin
      @(negedge clk);
      if (done1) seen = 1'b1;
    end
    checkOutput("midrst_no_done", seen, 0);

    for (int i = 0; i < 1000; i++) begin
      which = (i % 5 == 0) ? 4 : 1;
      ra = 8'($urandom); rb = 8'($urandom); rcin = 1'($urandom); rsub = 1'($urandom);
      applyStimulus(which, ra, rb, rcin, rsub, 1'b1, cyc);
      checkResult(which, ra, rb, rcin, rsub, cyc, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
